// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA colour constants, active-area defaults and ball FSM encoding
package vga_pkg;

    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_BOUNCE = 2'd2
    } ball_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-axis ball move with clamp to [0, ACTIVE-SIZE] and direction flip
module ball_axis_step #(
    parameter int ACTIVE = 640,
    parameter int SIZE   = 4,
    parameter int STEP   = 2
) (
    input  logic [15:0] pos_i,
    input  logic        dir_neg_i,
    output logic [15:0] next_pos_o,
    output logic        next_dir_neg_o
);

    localparam int MAX = ACTIVE - SIZE;

    logic [16:0] pos_ext;
    logic [16:0] sum;

    // 17-bit arithmetic so pos+STEP never wraps before the MAX compare
    always_comb begin
        pos_ext        = {1'b0, pos_i};
        sum            = pos_ext + 17'(STEP);
        next_pos_o     = pos_i;
        next_dir_neg_o = dir_neg_i;
        if (!dir_neg_i) begin
            if (sum > 17'(MAX)) begin
                next_pos_o     = 16'(MAX);
                next_dir_neg_o = 1'b1;
            end else begin
                next_pos_o = sum[15:0];
            end
        end else begin
            if (pos_ext < 17'(STEP)) begin
                next_pos_o     = 16'd0;
                next_dir_neg_o = 1'b0;
            end else begin
                next_pos_o = pos_i - 16'(STEP);
            end
        end
    end

endmodule

// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - bouncing square ball: vsync edge detect, per-frame move FSM, pixel renderer
module ball_renderer
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE         = H_ACTIVE_DEF,
    parameter int          V_ACTIVE         = V_ACTIVE_DEF,
    parameter int          BALL_SIZE        = 4,
    parameter int          H_INIT           = 128,
    parameter int          V_INIT           = 128,
    parameter int          H_STEP           = 2,
    parameter int          V_STEP           = 2,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [15:0] FG_COLOR         = 16'hFFFF,
    parameter logic [15:0] BG_COLOR         = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] row_i,
    input  logic [15:0] column_i,
    input  logic        vSync_i,
    input  logic        pause_i,
    output logic [15:0] rgb_o,
    output logic [15:0] ball_h_o,
    output logic [15:0] ball_v_o,
    output logic        frame_tick_o
);

    ball_state_t state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        trig_q, trig_d;
    logic [15:0] h_q, h_d, v_q, v_d;
    logic        h_neg_q, h_neg_d, v_neg_q, v_neg_d;
    logic [15:0] cand_h_q, cand_h_d, cand_v_q, cand_v_d;
    logic        cand_h_neg_q, cand_h_neg_d, cand_v_neg_q, cand_v_neg_d;
    logic        tick_q, tick_d;
    logic [15:0] rgb_q, rgb_d;

    logic        vs_active;
    logic [15:0] h_next, v_next;
    logic        h_next_neg, v_next_neg;
    logic [16:0] col_ext, row_ext, h_end, v_end;
    logic        hit;

    assign vs_active = VSYNC_ACTIVE_LOW ? ~vSync_i : vSync_i;

    ball_axis_step #(.ACTIVE(H_ACTIVE), .SIZE(BALL_SIZE), .STEP(H_STEP)) u_h_step (
        .pos_i          (h_q),
        .dir_neg_i      (h_neg_q),
        .next_pos_o     (h_next),
        .next_dir_neg_o (h_next_neg)
    );

    ball_axis_step #(.ACTIVE(V_ACTIVE), .SIZE(BALL_SIZE), .STEP(V_STEP)) u_v_step (
        .pos_i          (v_q),
        .dir_neg_i      (v_neg_q),
        .next_pos_o     (v_next),
        .next_dir_neg_o (v_next_neg)
    );

    // vsync_q holds the normalised (1 = active) level so the reset value is the inactive level
    always_comb begin
        vsync_d      = vs_active;
        trig_d       = vs_active & ~vsync_q;
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        h_neg_d      = h_neg_q;
        v_neg_d      = v_neg_q;
        cand_h_d     = cand_h_q;
        cand_v_d     = cand_v_q;
        cand_h_neg_d = cand_h_neg_q;
        cand_v_neg_d = cand_v_neg_q;
        tick_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_q && !pause_i) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cand_h_d     = h_next;
                cand_v_d     = v_next;
                cand_h_neg_d = h_next_neg;
                cand_v_neg_d = v_next_neg;
                state_d      = ST_BOUNCE;
            end
            ST_BOUNCE: begin
                h_d     = cand_h_q;
                v_d     = cand_v_q;
                h_neg_d = cand_h_neg_q;
                v_neg_d = cand_v_neg_q;
                tick_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_ext = {1'b0, column_i};
        row_ext = {1'b0, row_i};
        h_end   = {1'b0, h_q} + 17'(BALL_SIZE);
        v_end   = {1'b0, v_q} + 17'(BALL_SIZE);
        hit     = (col_ext < 17'(H_ACTIVE)) && (row_ext < 17'(V_ACTIVE)) &&
                  (column_i >= h_q) && (col_ext < h_end) &&
                  (row_i >= v_q) && (row_ext < v_end);
        rgb_d   = hit ? FG_COLOR : BG_COLOR;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            trig_q       <= 1'b0;
            h_q          <= 16'(H_INIT);
            v_q          <= 16'(V_INIT);
            h_neg_q      <= 1'b1;
            v_neg_q      <= 1'b0;
            cand_h_q     <= 16'(H_INIT);
            cand_v_q     <= 16'(V_INIT);
            cand_h_neg_q <= 1'b1;
            cand_v_neg_q <= 1'b0;
            tick_q       <= 1'b0;
            rgb_q        <= BG_COLOR;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            trig_q       <= trig_d;
            h_q          <= h_d;
            v_q          <= v_d;
            h_neg_q      <= h_neg_d;
            v_neg_q      <= v_neg_d;
            cand_h_q     <= cand_h_d;
            cand_v_q     <= cand_v_d;
            cand_h_neg_q <= cand_h_neg_d;
            cand_v_neg_q <= cand_v_neg_d;
            tick_q       <= tick_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb_o        = rgb_q;
    assign ball_h_o     = h_q;
    assign ball_v_o     = v_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_ball_renderer.sv
// tb/tb_ball_renderer.sv - self-checking bench for ball_renderer (two parameter sets, shared stimulus)
module tb_ball_renderer;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] row_i, column_i;
    logic        vSync_i, pause_i;
    logic [15:0] rgb_a, rgb_b, h_a, h_b, v_a, v_b;
    logic        tick_a, tick_b;

    int n_cmp = 0;
    int n_fail = 0;

    // model state: index 0 = default instance, 1 = edge-case instance
    int mh[2], mv[2];
    bit mhn[2], mvn[2];
    int hinit[2] = '{128, 1};
    int vinit[2] = '{128, 475};

    typedef struct {
        int          col;
        int          row;
        logic [15:0] exp;
    } rvec_t;
    rvec_t tbl[9];

    always #5 clk = ~clk;

    ball_renderer dut_a (
        .clk_i(clk), .reset_i(reset_i), .row_i(row_i), .column_i(column_i),
        .vSync_i(vSync_i), .pause_i(pause_i), .rgb_o(rgb_a),
        .ball_h_o(h_a), .ball_v_o(v_a), .frame_tick_o(tick_a)
    );

    ball_renderer #(.H_INIT(1), .V_INIT(475)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .row_i(row_i), .column_i(column_i),
        .vSync_i(vSync_i), .pause_i(pause_i), .rgb_o(rgb_b),
        .ball_h_o(h_b), .ball_v_o(v_b), .frame_tick_o(tick_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i] = hinit[i]; mv[i] = vinit[i]; mhn[i] = 1'b1; mvn[i] = 1'b0;
        end
    endtask

    // bounce on one axis: move, and if the ball would leave [0,lim] pin it to the wall and reverse
    task automatic model_axis(input int lim, input int st, input int pos, input bit neg,
                              output int npos, output bit nneg);
        int t;
        t = neg ? pos - st : pos + st;
        nneg = neg;
        npos = t;
        if (t > lim) begin npos = lim; nneg = 1'b1; end
        if (t < 0)   begin npos = 0;   nneg = 1'b0; end
    endtask

    task automatic model_frame();
        int p; bit d;
        for (int i = 0; i < 2; i++) begin
            model_axis(640 - 4, 2, mh[i], mhn[i], p, d); mh[i] = p; mhn[i] = d;
            model_axis(480 - 4, 2, mv[i], mvn[i], p, d); mv[i] = p; mvn[i] = d;
        end
    endtask

    function automatic int render(input int h, input int v, input int c, input int r);
        if (c >= 640 || r >= 480) return 0;
        if (c >= h && c < h + 4 && r >= v && r < v + 4) return 16'hFFFF;
        return 0;
    endfunction

    task automatic chk_pos(input string tag);
        chk({tag, "_ha"}, int'(h_a), mh[0]);
        chk({tag, "_va"}, int'(v_a), mv[0]);
        chk({tag, "_hb"}, int'(h_b), mh[1]);
        chk({tag, "_vb"}, int'(v_b), mv[1]);
    endtask

    // one vsync pulse (active low) starting on a falling edge; tick should first be seen 4 negedges later
    task automatic do_frame(input bit paused, input string tag);
        int lat, cnt_a, cnt_b;
        lat = 0; cnt_a = 0; cnt_b = 0;
        pause_i = paused;
        vSync_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) vSync_i = 1'b1;
            if (tick_a) begin cnt_a++; if (lat == 0) lat = k; end
            if (tick_b) cnt_b++;
        end
        pause_i = 1'b0;
        if (!paused) model_frame();
        chk({tag, "_ticks_a"}, cnt_a, paused ? 0 : 1);
        chk({tag, "_ticks_b"}, cnt_b, paused ? 0 : 1);
        if (!paused) chk({tag, "_tick_lat"}, lat, 4);
        chk_pos(tag);
    endtask

    task automatic probe(input int c, input int r, input string tag);
        column_i = 16'(c);
        row_i    = 16'(r);
        @(negedge clk);
        chk({tag, "_rgb_a"}, int'(rgb_a), render(mh[0], mv[0], c, r));
        chk({tag, "_rgb_b"}, int'(rgb_b), render(mh[1], mv[1], c, r));
    endtask

    initial begin
        tbl[0] = '{128, 128, 16'hFFFF};
        tbl[1] = '{131, 131, 16'hFFFF};
        tbl[2] = '{132, 128, 16'h0000};
        tbl[3] = '{127, 128, 16'h0000};
        tbl[4] = '{700, 128, 16'h0000};
        tbl[5] = '{128, 127, 16'h0000};
        tbl[6] = '{128, 132, 16'h0000};
        tbl[7] = '{130, 129, 16'hFFFF};
        tbl[8] = '{129, 600, 16'h0000};

        reset_i = 1'b1; vSync_i = 1'b1; pause_i = 1'b0; row_i = 0; column_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_h", int'(h_a), 128);
        chk("rst_v", int'(v_a), 128);
        chk("rst_rgb", int'(rgb_a), 0);
        chk("rst_tick", int'(tick_a), 0);
        chk("rst_hb", int'(h_b), 1);
        chk("rst_vb", int'(v_b), 475);
        reset_i = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            column_i = 16'(tbl[i].col);
            row_i    = 16'(tbl[i].row);
            @(negedge clk);
            chk($sformatf("tbl%0d_rgb", i), int'(rgb_a), int'(tbl[i].exp));
        end

        do_frame(1'b0, "f1");
        chk("f1_h126", int'(h_a), 126);
        chk("f1_v130", int'(v_a), 130);
        chk("f1_left_h0", int'(h_b), 0);
        chk("f1_bot_v476", int'(v_b), 476);
        do_frame(1'b0, "f2");
        chk("f2_left_h2", int'(h_b), 2);
        chk("f2_bot_v474", int'(v_b), 474);

        for (int i = 0; i < 3; i++) do_frame(1'b1, $sformatf("pause%0d", i));
        do_frame(1'b0, "unpause");

        // reset asserted while the FSM is in STEP
        vSync_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        vSync_i = 1'b1;
        #1;
        model_reset();
        chk_pos("arst");
        chk("arst_rgb", int'(rgb_a), 0);
        chk("arst_tick", int'(tick_a), 0);
        chk("arst_state", int'(dut_a.state_q), int'(ST_IDLE));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_notick", int'(tick_a), 0);
        end
        reset_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_notick", int'(tick_a), 0);
        end
        chk_pos("post_rst");
        do_frame(1'b0, "post_rst_f1");

        for (int it = 0; it < 25; it++) begin
            do_frame($urandom_range(0, 3) == 0, $sformatf("rnd%0d", it));
            for (int p = 0; p < 6; p++) begin
                int c, r, w;
                w = $urandom_range(0, 1);
                c = mh[w] + int'($urandom_range(0, 9)) - 3;
                r = mv[w] + int'($urandom_range(0, 9)) - 3;
                if (c < 0) c = 0;
                if (r < 0) r = 0;
                if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 1023);
                probe(c, r, $sformatf("rnd%0d_p%0d", it, p));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
